// File: rtl/uart_resp_pkg.sv
// Shared state encoding, opcodes and reply bytes for the UART command responder.
package uart_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_EXEC     = 3'd3,
    S_SEND     = 3'd4,
    S_ECHO     = 3'd5
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RPL_ACK  = 8'h4B;
  localparam logic [7:0] RPL_ERR  = 8'h3F;

endpackage

// File: rtl/uart_resp_regfile.sv
// Register file for the command responder: one write port, one async read port.
module uart_resp_regfile #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DBIT-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DBIT-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DBIT-1:0] mem_q [DEPTH];
  logic [DBIT-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_cmd_responder.sv
// UART command responder: 'W' addr data / 'R' addr protocol over FWFT rx/tx FIFOs.
// Optional echo of every popped byte is enabled by defining UART_RESP_ECHO_EN.
module uart_cmd_responder
  import uart_resp_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [DBIT-1:0] w_data,
  output logic            wr_uart,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  localparam logic [DBIT-1:0] OP_W = DBIT'(OP_WRITE);
  localparam logic [DBIT-1:0] OP_R = DBIT'(OP_READ);

  state_t            state_q, state_d;
  logic [DBIT-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DBIT-1:0]   data_q, data_d;
  logic [DBIT-1:0]   w_data_q, w_data_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              reg_we;
  logic [DBIT-1:0]   reg_rdata;
`ifdef UART_RESP_ECHO_EN
  state_t            ret_q, ret_d;
`endif

  uart_resp_regfile #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .waddr (addr_q),
    .wdata (data_q),
    .raddr (addr_q),
    .rdata (reg_rdata)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    w_data_d  = w_data_q;
    err_cnt_d = err_cnt_q;
    rd_uart   = 1'b0;
    wr_uart   = 1'b0;
    reg_we    = 1'b0;
`ifdef UART_RESP_ECHO_EN
    ret_d     = ret_q;
`endif
    case (state_q)
      S_IDLE: if (!rx_empty) begin
        rd_uart  = 1'b1;
        opcode_d = r_data;
        state_d  = (r_data == OP_W || r_data == OP_R) ? S_GET_ADDR : S_EXEC;
      end
      S_GET_ADDR: if (!rx_empty) begin
        rd_uart = 1'b1;
        addr_d  = r_data[ADDR_W-1:0];
        state_d = (opcode_q == OP_W) ? S_GET_DATA : S_EXEC;
      end
      S_GET_DATA: if (!rx_empty) begin
        rd_uart = 1'b1;
        data_d  = r_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode_q == OP_W) begin
          reg_we   = 1'b1;
          w_data_d = DBIT'(RPL_ACK);
        end else if (opcode_q == OP_R) begin
          w_data_d = reg_rdata;
        end else begin
          w_data_d = DBIT'(RPL_ERR);
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = S_SEND;
      end
      S_SEND: if (!tx_full) begin
        wr_uart = 1'b1;
        state_d = S_IDLE;
      end
`ifdef UART_RESP_ECHO_EN
      S_ECHO: if (!tx_full) begin
        wr_uart = 1'b1;
        state_d = ret_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef UART_RESP_ECHO_EN
    // Every pop detours through ECHO; the real next state is parked in ret_q
    // and the popped byte reuses the w_data register as the echo payload.
    if (rd_uart) begin
      ret_d    = state_d;
      state_d  = S_ECHO;
      w_data_d = r_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      w_data_q  <= '0;
      err_cnt_q <= '0;
`ifdef UART_RESP_ECHO_EN
      ret_q     <= S_IDLE;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      w_data_q  <= w_data_d;
      err_cnt_q <= err_cnt_d;
`ifdef UART_RESP_ECHO_EN
      ret_q     <= ret_d;
`endif
    end
  end

  assign w_data  = w_data_q;
  assign err_cnt = err_cnt_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: FIFO models on both sides and a
// command-level model predicting every transmitted byte and the error count.
module tb_uart_cmd_responder;

`ifdef UART_RESP_ECHO_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [7:0] val;
    logic       reply;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       busy;
  logic [7:0] err_cnt;

  logic [7:0] rx_q[$];
  exp_t       exp_q[$];
  logic [7:0] model_reg [16];
  int         model_err;
  logic [7:0] last_tx;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         last_pop = 0;
  bit         full_seen;

  uart_cmd_responder #(
    .DBIT   (8),
    .ADDR_W (4)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Receive FIFO model and per-cycle comparison against the expected tx stream.
  initial begin
    bit   pop_req;
    exp_t e;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      pop_req = 1'b0;
      if (!rst) begin
        if (rd_uart || wr_uart) chk("strobe_exclusive", {31'b0, rd_uart & wr_uart}, 32'd0);
        if (rd_uart) begin
          chk("pop_when_nonempty", {31'b0, rx_empty}, 32'd0);
          pop_req   = 1'b1;
          last_pop  = cyc;
          full_seen = 1'b0;
        end
        if (tx_full) full_seen = 1'b1;
        if (wr_uart) begin
          chk("push_when_not_full", {31'b0, tx_full}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx got=%02h expected=none t=%0t", w_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'b0, w_data}, {24'b0, e.val});
            last_tx = w_data;
            if (e.reply && !full_seen) chk("reply_latency", cyc - last_pop, LAT);
          end
        end
      end
      @(posedge clk);
      #1;
      if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_q.push_back(b);
`ifdef UART_RESP_ECHO_EN
    exp_q.push_back(exp_t'{val: b, reply: 1'b0});
`endif
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57); send_byte(a); send_byte(d);
    model_reg[a % 16] = d;
    exp_q.push_back(exp_t'{val: 8'h4B, reply: 1'b1});
  endtask

  task automatic do_read(input logic [7:0] a);
    send_byte(8'h52); send_byte(a);
    exp_q.push_back(exp_t'{val: model_reg[a % 16], reply: 1'b1});
  endtask

  task automatic do_unknown(input logic [7:0] op);
    send_byte(op);
    if (model_err < 255) model_err++;
    exp_q.push_back(exp_t'{val: 8'h3F, reply: 1'b1});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_reg[i] = 8'h00;
    model_err = 0;
  endtask

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy expected=idle within %0d cycles", limit);
    end
    chk("err_cnt_model", {24'b0, err_cnt}, model_err);
  endtask

  initial begin
    logic [7:0] op;
    bit         seen;
    rst     = 1'b1;
    tx_full = 1'b0;
    last_tx = 8'hxx;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy",    {31'b0, busy},    32'd0);
    chk("reset_rd",      {31'b0, rd_uart}, 32'd0);
    chk("reset_wr",      {31'b0, wr_uart}, 32'd0);
    chk("reset_w_data",  {24'b0, w_data},  32'h00);
    chk("reset_err_cnt", {24'b0, err_cnt}, 32'h00);
    @(posedge clk); #2;
    rst = 1'b0;

    // Read with upper address bits set wraps to entry 0xF, still at reset value.
    do_read(8'h1F);
    wait_idle(100);
    chk("read_1f_literal", {24'b0, last_tx}, 32'h00);

    do_write(8'h03, 8'hA5);
    wait_idle(100);
    chk("write_ack_literal", {24'b0, last_tx}, 32'h4B);
    do_read(8'h03);
    wait_idle(100);
    chk("read_back_literal", {24'b0, last_tx}, 32'hA5);

    for (int i = 0; i < 3; i++) do_unknown(8'h00);
    wait_idle(200);
    chk("err_cnt_3_literal", {24'b0, err_cnt}, 32'd3);

    // Back-to-back write then read, queued together, plus aliased addresses.
    do_write(8'h07, 8'h3C); do_read(8'h07);
    do_write(8'h2A, 8'h5A); do_read(8'h0A);
    do_write(8'hF0, 8'hFF); do_read(8'h00);
    do_write(8'h0A, 8'h01); do_read(8'hEA);
    do_unknown(8'h77);
    do_read(8'h03);
    wait_idle(400);
    chk("read_alias_literal", {24'b0, last_tx}, 32'hA5);

    // Reply held off by a full tx FIFO.
    tx_full = 1'b1;
    do_read(8'h07);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held_wr_low", {31'b0, wr_uart}, 32'd0);
      chk("held_busy",   {31'b0, busy},    32'd1);
    end
    @(posedge clk); #2;
    tx_full = 1'b0;
    wait_idle(100);
    chk("held_reply_literal", {24'b0, last_tx}, 32'h3C);

    // Saturation of the unknown-opcode counter.
    for (int i = 0; i < 260; i++) begin
      op = 8'($urandom_range(0, 255));
      while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
      do_unknown(op);
    end
    wait_idle(5000);
    chk("err_cnt_sat_literal", {24'b0, err_cnt}, 32'hFF);

    // Reset in the middle of a write command discards it without a reply.
    do_write(8'h02, 8'h77);
    wait_idle(100);
    send_byte(8'h57); send_byte(8'h02);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #2;
      if (rx_q.size() == 0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL partial_pop_timeout got=pending expected=popped");
    end
    rst = 1'b1;
    #1;
    chk("mid_reset_busy",    {31'b0, busy},    32'd0);
    chk("mid_reset_wr",      {31'b0, wr_uart}, 32'd0);
    chk("mid_reset_err_cnt", {24'b0, err_cnt}, 32'h00);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    do_read(8'h02);
    wait_idle(100);
    chk("post_reset_read_literal", {24'b0, last_tx}, 32'h00);
    repeat (5) @(negedge clk);
    chk("no_stray_tx", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter DBIT, 8, data width of UART host-side bytes; all byte-wide ports, opcodes and register entries SHALL use this width.
REQ-002 Parameter ADDR_W, 4, register-file index width (2**ADDR_W entries).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_empty  in  1  UART receive FIFO empty flag.
REQ-006 r_data  in  DBIT  receive FIFO head byte, first-word-fall-through, valid whenever rx_empty=0.
REQ-007 rd_uart  out  1  one-cycle pop strobe to receive FIFO.
REQ-008 tx_full  in  1  UART transmit FIFO full flag.
REQ-009 w_data  out  DBIT  byte pushed to transmit FIFO.
REQ-010 wr_uart  out  1  one-cycle push strobe to transmit FIFO.
REQ-011 busy  out  1  high whenever FSM not in IDLE.
REQ-012 err_cnt  out  8  count of unknown opcodes, saturating.

Function
REQ-013 Protocol: 'W'(0x57) addr data -> reg[addr[ADDR_W-1:0]]<=data, reply 0x4B; 'R'(0x52) addr -> reply reg[addr[ADDR_W-1:0]]; any other opcode -> reply 0x3F, no further bytes consumed.
REQ-014 Upper addr bits above ADDR_W SHALL be ignored.
REQ-015 FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND (plus ECHO, see REQ-026).
REQ-016 IDLE/GET_ADDR/GET_DATA: rd_uart=1 only in a cycle with rx_empty=0; r_data captured that same cycle; state advances at that edge; waits indefinitely while rx_empty=1.
REQ-017 Transitions: IDLE->GET_ADDR on valid opcode, IDLE->EXEC on unknown opcode; GET_ADDR->GET_DATA for 'W', ->EXEC for 'R'; GET_DATA->EXEC; EXEC->SEND unconditionally; SEND->IDLE on push.
REQ-018 EXEC: single cycle; register write committed at end of EXEC; response byte latched into w_data.
REQ-019 SEND: wr_uart=1 only in a cycle with tx_full=0; holds in SEND with wr_uart=0 while tx_full=1.
REQ-020 Latency: last byte popped in cycle N -> wr_uart earliest in cycle N+2.
REQ-021 rd_uart and wr_uart SHALL never be high in the same cycle; at most one pop per cycle.
REQ-022 'R' to an address written by an immediately preceding 'W' SHALL return the new value.
REQ-023 err_cnt increments by 1 in EXEC for unknown opcodes; holds at 0xFF.

Reset
REQ-024 On reset assertion, regardless of state: FSM->IDLE, rd_uart=0, wr_uart=0, w_data=0x00, busy=0, err_cnt=0x00, all register entries=0x00; partially received commands discarded with no reply.
REQ-025 After reset deassertion, first pop no earlier than the first rising edge with reset low.

Configuration
REQ-026 UART_RESP_ECHO_EN defined: after every pop, FSM enters ECHO and pushes the popped byte (wr_uart under tx_full rule of REQ-019) before returning to the next receive state or EXEC; reply latency becomes N+3 minimum. Undefined: no ECHO state, no echo bytes, REQ-020 timing applies.

Structure
REQ-027 Package uart_resp_pkg SHALL hold the state enum typedef, opcode constants (0x57, 0x52), reply constants (0x4B, 0x3F).
REQ-028 Register file SHALL be sub-module uart_resp_regfile (1 write port, 1 async read port, async reset).

Verification
REQ-029 Push 0x57,0x03,0xA5 -> exactly one tx byte 0x4B; then push 0x52,0x03 -> tx byte 0xA5.
REQ-030 Push 0x52,0x1F after reset -> tx byte 0x00 (addr wraps to 0xF, reset value).
REQ-031 Push 0x00 three times -> tx bytes 0x3F,0x3F,0x3F; err_cnt=3; 256+ unknowns -> err_cnt=0xFF.
REQ-032 Hold tx_full=1 for 20 cycles during 'R' reply -> wr_uart stays 0, busy=1; single push after tx_full drops.
REQ-033 Assert reset after 0x57,0x02 popped -> busy=0 immediately, no reply; next 0x52,0x02 -> 0x00.
REQ-034 With UART_RESP_ECHO_EN, push 0x52,0x05 -> tx sequence 0x52,0x05,reg[5].
